// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state type, common to the RX and TX paths.
package uart_pkg;
   localparam int unsigned OS_RATE   = 16;
   localparam int unsigned OS_MID    = 7;
   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake and status bundle between uart_rx and its consumer.
interface uart_rx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] d_rx;
   logic                 vld_rx;
   logic                 rdy_rx;
   logic                 ferr;
   logic                 ovr;
   logic                 busy;

   modport master (output d_rx, output vld_rx, output ferr, output ovr, output busy,
                   input  rdy_rx);
   modport slave  (input  d_rx, input  vld_rx, input  ferr, input  ovr, input  busy,
                   output rdy_rx);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, parked at zero while clr is high.
module uart_baud_tick #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   if (DIV < 1) begin : g_bad_div
      $error("uart_baud_tick: DIV must be >= 1");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = !clr && (cnt_q == CNT_W'(DIV - 1));
      cnt_d = (clr || tick) ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, mid-bit sampling, byte delivery on a vld/rdy handshake.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned DIV      = CLK_FREQ / (BAUD * 16)
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rx,
   uart_rx_if.master bus
);
   logic                 rx_meta_q, rx_s_q;
   uart_state_e          state_q, state_d;
   logic [3:0]           os_q, os_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] d_q, d_d;
   logic                 vld_q, vld_d, ferr_q, ferr_d, ovr_q, ovr_d;
   logic                 tick, clr, stop_smp, deliver;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= ST_IDLE;
         os_q      <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         d_q       <= '0;
         vld_q     <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         os_q      <= os_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         d_q       <= d_d;
         vld_q     <= vld_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      os_d    = os_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               state_d = ST_START;
               os_d    = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               if (os_q == 4'(OS_MID)) begin
                  // Line back high at mid start bit: treat as a glitch.
                  if (rx_s_q) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DATA;
                     os_d    = '0;
                     bit_d   = '0;
                  end
               end else begin
                  os_d = os_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (os_q == 4'(OS_RATE - 1)) begin
                  shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                  os_d    = '0;
                  if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
                  else                            bit_d   = bit_q + 3'd1;
               end else begin
                  os_d = os_q + 4'd1;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (os_q == 4'(OS_RATE - 1)) begin
                  state_d = ST_IDLE;
                  os_d    = '0;
               end else begin
                  os_d = os_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      clr      = (state_q == ST_IDLE);
      stop_smp = (state_q == ST_STOP) && tick && (os_q == 4'(OS_RATE - 1));
      deliver  = stop_smp && rx_s_q;
      ferr_d   = stop_smp && !rx_s_q;
      ovr_d    = 1'b0;
      d_d      = d_q;
      vld_d    = vld_q && !bus.rdy_rx;
      // A consume in the same cycle frees the holding register for the new byte.
      if (deliver) begin
         if (!vld_q || bus.rdy_rx) begin
            d_d   = shift_q;
            vld_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign bus.d_rx   = d_q;
   assign bus.vld_rx = vld_q;
   assign bus.ferr   = ferr_q;
   assign bus.ovr    = ovr_q;
   assign bus.busy   = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written corner sequences.
module tb_uart_rx;
   localparam int unsigned BIT_CLKS = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rx  = 1'b1;

   uart_rx_if u_if ();

   uart_rx #(.CLK_FREQ(614_400), .BAUD(9600)) dut (
      .clk (clk),
      .rst (rst),
      .rx  (rx),
      .bus (u_if.master)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int ferr_cnt, ovr_cnt, vld_cycles, both_cnt;
   logic [7:0] xfer_q[$];

   initial begin
      ferr_cnt = 0; ovr_cnt = 0; vld_cycles = 0; both_cnt = 0;
   end

   always @(negedge clk) begin
      if (rst) begin
         if (u_if.vld_rx && u_if.rdy_rx) xfer_q.push_back(u_if.d_rx);
         if (u_if.ferr) ferr_cnt++;
         if (u_if.ovr) ovr_cnt++;
         if (u_if.ferr && u_if.ovr) both_cnt++;
         if (u_if.vld_rx) vld_cycles++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      ferr_cnt = 0; ovr_cnt = 0; vld_cycles = 0;
      xfer_q.delete();
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (BIT_CLKS) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_xfers;
      int         exp_ferr;
      int         exp_vld_cyc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h55, 1'b1, 1, 0, 1};
      vecs[1] = '{8'hA3, 1'b0, 0, 1, 0};
      vecs[2] = '{8'h3C, 1'b1, 1, 0, 1};
      vecs[3] = '{8'h80, 1'b1, 1, 0, 1};
      vecs[4] = '{8'h01, 1'b1, 1, 0, 1};
      vecs[5] = '{8'hC6, 1'b1, 1, 0, 1};

      u_if.rdy_rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_d_rx", u_if.d_rx, 0);
      check("reset_vld", u_if.vld_rx, 0);
      check("reset_ferr", u_if.ferr, 0);
      check("reset_ovr", u_if.ovr, 0);
      check("reset_busy", u_if.busy, 0);
      rst = 1'b1;
      send_bit(1'b1);

      u_if.rdy_rx = 1'b1;
      for (int v = 0; v < 6; v++) begin
         clear_mon();
         send_frame(vecs[v].data, vecs[v].stop);
         send_bit(1'b1);
         check($sformatf("vec%0d_xfers", v), xfer_q.size(), vecs[v].exp_xfers);
         if (xfer_q.size() > 0) check($sformatf("vec%0d_data", v), xfer_q[0], vecs[v].data);
         check($sformatf("vec%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
         check($sformatf("vec%0d_ovr", v), ovr_cnt, 0);
         check($sformatf("vec%0d_vld_cycles", v), vld_cycles, vecs[v].exp_vld_cyc);
      end

      // Start-bit glitch: 12 clocks low.
      clear_mon();
      rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("glitch_busy_hi", u_if.busy, 1);
      repeat (7) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("glitch_busy_lo", u_if.busy, 0);
      send_bit(1'b1);
      check("glitch_vld", vld_cycles, 0);
      check("glitch_ferr", ferr_cnt, 0);

      // Overrun: consumer stalled across two frames.
      u_if.rdy_rx = 1'b0;
      clear_mon();
      send_frame(8'h12, 1'b1);
      send_bit(1'b1);
      send_frame(8'h34, 1'b1);
      send_bit(1'b1);
      check("ovr_count", ovr_cnt, 1);
      check("ovr_vld_held", u_if.vld_rx, 1);
      check("ovr_d_held", u_if.d_rx, 8'h12);
      check("ovr_no_xfer", xfer_q.size(), 0);
      u_if.rdy_rx = 1'b1;
      @(posedge clk);
      #1;
      u_if.rdy_rx = 1'b0;
      check("ovr_vld_drop", u_if.vld_rx, 0);
      check("ovr_d_after", u_if.d_rx, 8'h12);
      check("ovr_xfer_cnt", xfer_q.size(), 1);
      if (xfer_q.size() > 0) check("ovr_xfer_data", xfer_q[0], 8'h12);

      // Reset in the middle of data bit 4.
      u_if.rdy_rx = 1'b1;
      clear_mon();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rx = 1'b0;
      repeat (32) @(posedge clk);
      #1;
      check("midrst_busy_pre", u_if.busy, 1);
      rst = 1'b0;
      rx  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_d_rx", u_if.d_rx, 0);
      check("midrst_vld", u_if.vld_rx, 0);
      check("midrst_busy", u_if.busy, 0);
      rst = 1'b1;
      send_bit(1'b1);
      clear_mon();
      send_frame(8'hF0, 1'b1);
      send_bit(1'b1);
      check("midrst_xfers", xfer_q.size(), 1);
      if (xfer_q.size() > 0) check("midrst_data", xfer_q[0], 8'hF0);
      check("midrst_ferr", ferr_cnt, 0);

      // Back-to-back frames, consumer always ready.
      clear_mon();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_bit(1'b1);
      check("b2b_xfers", xfer_q.size(), 2);
      if (xfer_q.size() > 1) begin
         check("b2b_first", xfer_q[0], 8'h00);
         check("b2b_second", xfer_q[1], 8'hFF);
      end
      check("b2b_ferr", ferr_cnt, 0);
      check("b2b_ovr", ovr_cnt, 0);

      // Consume coinciding with the second delivery (stop sample is 611 clocks after start edge).
      u_if.rdy_rx = 1'b0;
      clear_mon();
      send_frame(8'h00, 1'b1);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (610) @(posedge clk);
            #1;
            u_if.rdy_rx = 1'b1;
            @(posedge clk);
            #1;
            u_if.rdy_rx = 1'b0;
         end
      join
      check("coinc_ovr", ovr_cnt, 0);
      check("coinc_vld", u_if.vld_rx, 1);
      check("coinc_d_rx", u_if.d_rx, 8'hFF);
      check("coinc_xfers", xfer_q.size(), 1);
      if (xfer_q.size() > 0) check("coinc_xfer_data", xfer_q[0], 8'h00);
      u_if.rdy_rx = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      check("never_ferr_and_ovr", both_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
